// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer between the EX-stage ALU and a multi-cycle divider core.
// Latches the operands once, drives start/cancel/signed to the core, stalls the
// pipeline while the core works and issues exactly one HI/LO write per divide.
// A watchdog aborts a core that never answers and raises a sticky timeout flag.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   When defined, a divide by zero skips the core and goes straight to DONE
//   with {HI, LO} = {dividend, all-ones}. When undefined, the core handles it.
//
// Core handshake: div_start is a level held high for the whole of BUSY and is
// dropped in the same cycle div_cancel pulses. The core result is accepted in
// the first BUSY cycle where div_ready is high. div_cancel is a single-cycle
// abort that is only ever raised from BUSY.
module div_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_req,
    input  logic                 div_signed_i,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    input  logic                 hold,
    input  logic                 div_ready,
    input  logic [2*WIDTH-1:0]   div_result,
    output logic                 div_start,
    output logic                 div_cancel,
    output logic                 div_signed_o,
    output logic [WIDTH-1:0]     div_opa,
    output logic [WIDTH-1:0]     div_opb,
    output logic                 div_stall,
    output logic                 hilo_we,
    output logic [2*WIDTH-1:0]   hilo_wdata,
    output logic                 timeout,
    output logic [1:0]           dbg_state_o
);

    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   wdata_q, wdata_d;
    logic                 timeout_q, timeout_d;

    logic                 start_c;
    logic                 cancel_c;
    logic                 stall_c;
    logic                 we_c;

    // State and datapath registers; reset clears everything without a cancel pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            sgn_q     <= 1'b0;
            wdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sgn_q     <= sgn_d;
            wdata_q   <= wdata_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and handshake decode; in BUSY flush beats ready beats watchdog.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sgn_d     = sgn_q;
        wdata_d   = wdata_q;
        timeout_d = timeout_q;
        start_c   = 1'b0;
        cancel_c  = 1'b0;
        stall_c   = 1'b0;
        we_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (div_req && !flush) begin
                    // Stall immediately so EX does not advance past the divide.
                    stall_c = 1'b1;
                    opa_d   = a;
                    opb_d   = b;
                    sgn_d   = div_signed_i;
                    cnt_d   = '0;
                    state_d = S_BUSY;
`ifdef DIV_ZERO_BYPASS_EN
                    if (b == '0) begin
                        wdata_d = {a, {WIDTH{1'b1}}};
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_BUSY: begin
                stall_c = 1'b1;
                start_c = 1'b1;
                if (flush) begin
                    cancel_c = 1'b1;
                    start_c  = 1'b0;
                    state_d  = S_IDLE;
                end else if (div_ready) begin
                    wdata_d = div_result;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cancel_c  = 1'b1;
                    start_c   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                // Leave only when EX advances, so the same instruction cannot re-trigger.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    we_c    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign div_start    = start_c;
    assign div_cancel   = cancel_c;
    assign div_stall    = stall_c & ~rst;
    assign hilo_we      = we_c;
    assign div_signed_o = sgn_q;
    assign div_opa      = opa_q;
    assign div_opb      = opb_q;
    assign hilo_wdata   = wdata_q;
    assign timeout      = timeout_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed divides against a behavioural divider core,
// HI/LO writes checked by a scoreboard queue, handshake details checked inline.
module tb_div_seq_ctrl;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic            clk;
    logic            rst;
    logic            div_req;
    logic            div_signed_i;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic            flush;
    logic            hold;
    logic            div_ready;
    logic [2*W-1:0]  div_result;
    logic            div_start;
    logic            div_cancel;
    logic            div_signed_o;
    logic [W-1:0]    div_opa;
    logic [W-1:0]    div_opb;
    logic            div_stall;
    logic            hilo_we;
    logic [2*W-1:0]  hilo_wdata;
    logic            timeout;
    logic [1:0]      dbg_state;

    div_seq_ctrl #(.WIDTH(W), .MAX_CYCLES(40)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .div_signed_i (div_signed_i),
        .a            (a_in),
        .b            (b_in),
        .flush        (flush),
        .hold         (hold),
        .div_ready    (div_ready),
        .div_result   (div_result),
        .div_start    (div_start),
        .div_cancel   (div_cancel),
        .div_signed_o (div_signed_o),
        .div_opa      (div_opa),
        .div_opb      (div_opb),
        .div_stall    (div_stall),
        .hilo_we      (hilo_we),
        .hilo_wdata   (hilo_wdata),
        .timeout      (timeout),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural divider core ----------------
    logic core_dead;
    int   core_cnt;

    function automatic logic [2*W-1:0] core_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic sgn);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ready  <= 1'b0;
            div_result <= '0;
            core_cnt   <= 0;
        end else if (div_start && !div_ready && !core_dead) begin
            if (core_cnt == LAT - 1) begin
                div_ready  <= 1'b1;
                div_result <= core_div(div_opa, div_opb, div_signed_o);
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end else if (!div_start) begin
            div_ready <= 1'b0;
            core_cnt  <= 0;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [2*W-1:0] exp_q[$];
    int n_cmp;
    int n_err;
    int stall_tot, we_tot, start_tot, cancel_tot;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tallies handshake activity and checks every HI/LO write against the queue.
    task automatic monitor_loop();
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_tot  += int'(div_stall);
                we_tot     += int'(hilo_we);
                start_tot  += int'(div_start);
                cancel_tot += int'(div_cancel);
                if (hilo_we) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL hilo_unexpected: got write %h expected none at %0t",
                                 hilo_wdata, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (hilo_wdata !== e) begin
                            n_err++;
                            $display("FAIL hilo_wdata: got %h expected %h at %0t",
                                     hilo_wdata, e, $time);
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  div_start, 0);
        check({tag, "_cancel"}, div_cancel, 0);
        check({tag, "_signed"}, div_signed_o, 0);
        check({tag, "_opa"},    div_opa, 0);
        check({tag, "_opb"},    div_opb, 0);
        check({tag, "_stall"},  div_stall, 0);
        check({tag, "_we"},     hilo_we, 0);
        check({tag, "_wdata"},  hilo_wdata, 0);
        check({tag, "_state"},  dbg_state, 0);
    endtask

    // Issue one divide from IDLE and follow it to the HI/LO write.
    task automatic run_div(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp, input int hold_n, input int exp_stall,
                           input logic exp_started);
        int s0, w0, st0, n;
        s0  = stall_tot;
        w0  = we_tot;
        st0 = start_tot;
        exp_q.push_back(exp);
        div_req      = 1'b1;
        div_signed_i = sgn;
        a_in         = av;
        b_in         = bv;
        hold         = (hold_n > 0);
        step();
        // Operands must stay latched even if the source registers change.
        a_in         = $urandom;
        b_in         = $urandom;
        div_signed_i = ~sgn;
        #1;
        check("latched_signed", div_signed_o, sgn);
        check("latched_opa", div_opa, av);
        check("latched_opb", div_opb, bv);
        n = 0;
        while (div_stall && n < 200) begin
            step();
            n++;
        end
        check("busy_bounded", n < 200, 1);
        for (int i = 0; i < hold_n; i++) begin
            @(negedge clk);
            check("hold_no_we", hilo_we, 0);
            check("hold_no_stall", div_stall, 0);
            step();
        end
        hold = 1'b0;
        step();
        div_req = 1'b0;
        check("stall_cycles", stall_tot - s0, exp_stall);
        check("we_pulses", we_tot - w0, 1);
        check("core_started", (start_tot - st0) > 0, exp_started);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, w0;
        n_cmp = 0; n_err = 0;
        stall_tot = 0; we_tot = 0; start_tot = 0; cancel_tot = 0;
        core_dead = 1'b0;
        rst = 1'b1; div_req = 1'b0; div_signed_i = 1'b0;
        a_in = '0; b_in = '0; flush = 1'b0; hold = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset_timeout", timeout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Signed 100/7: 1 IDLE + 34 BUSY stall cycles.
        run_div(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 35, 1'b1);
        // Unsigned with top bits set.
        run_div(1'b0, 32'hFFFFFFF0, 32'd16, {32'd0, 32'h0FFFFFFF}, 0, 35, 1'b1);
        // Signed negative dividend, held 3 cycles in DONE.
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 3, 35, 1'b1);
        // Back-to-back unsigned.
        run_div(1'b0, 32'd12345, 32'd100, {32'd45, 32'd123}, 0, 35, 1'b1);
        // Divide by zero.
`ifdef DIV_ZERO_BYPASS_EN
        run_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 0, 1, 1'b0);
`else
        run_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 0, 35, 1'b1);
`endif
        step();

        // Flush 5 cycles into BUSY.
        w0 = we_tot; c0 = cancel_tot;
        div_req = 1'b1; div_signed_i = 1'b0; a_in = 32'd77; b_in = 32'd3;
        step();
        repeat (4) step();
        flush = 1'b1;
        @(negedge clk);
        check("flush_cancel", div_cancel, 1);
        check("flush_start_drop", div_start, 0);
        step();
        flush = 1'b0; div_req = 1'b0;
        @(negedge clk);
        check("flush_idle_cancel", div_cancel, 0);
        check("flush_idle_stall", div_stall, 0);
        check("flush_idle_start", div_start, 0);
        repeat (3) step();
        check("flush_no_we", we_tot - w0, 0);
        check("flush_one_cancel", cancel_tot - c0, 1);

        // Watchdog: core never answers.
        core_dead = 1'b1;
        div_req = 1'b1; a_in = 32'd9; b_in = 32'd4;
        step();
        repeat (38) step();
        @(negedge clk);
        check("wd_cycle39_cancel", div_cancel, 0);
        step();
        @(negedge clk);
        check("wd_cycle40_cancel", div_cancel, 1);
        check("wd_cycle40_start", div_start, 0);
        check("wd_cycle40_timeout", timeout, 0);
        step();
        div_req = 1'b0;
        @(negedge clk);
        check("wd_timeout_set", timeout, 1);
        check("wd_idle_stall", div_stall, 0);
        check("wd_idle_cancel", div_cancel, 0);
        core_dead = 1'b0;
        step();

        // Normal divide after a timeout; flag stays sticky.
        run_div(1'b1, 32'd9, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFC}, 0, 35, 1'b1);
        check("timeout_sticky", timeout, 1);

        // Reset in the middle of BUSY.
        c0 = cancel_tot;
        div_req = 1'b1; a_in = 32'd50; b_in = 32'd5;
        repeat (10) step();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst_timeout", timeout, 0);
        div_req = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("midrst_no_cancel", cancel_tot - c0, 0);
        check("midrst_idle", dbg_state, 0);

        step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t, expected finish", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencer for the multi-cycle divider core used by the EX-stage ALU for DIV/DIVU.
- Latches operands once and drives the core's start/cancel/signed handshake.
- Raises the pipeline stall while the core is busy and writes the result to HI/LO once.
- Cancels the core on exception/flush and flags a core that never responds.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- MAX_CYCLES, 40, BUSY cycles allowed before the watchdog aborts (must be >= core latency + 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- div_req  input  1  EX holds a DIV or DIVU (level, held while stalled)
- div_signed_i  input  1  1 = DIV, 0 = DIVU
- a  input  WIDTH  dividend (rs)
- b  input  WIDTH  divisor (rt)
- flush  input  1  exception/flush of EX (isexceptM | flushE)
- hold  input  1  external pipeline stall; EX cannot advance
- div_ready  input  1  core result valid
- div_result  input  2*WIDTH  core result {remainder, quotient}
- div_start  output  1  core start, held high until ready/cancel
- div_cancel  output  1  one-cycle core abort
- div_signed_o  output  1  latched signedness to core
- div_opa  output  WIDTH  latched dividend to core
- div_opb  output  WIDTH  latched divisor to core
- div_stall  output  1  stall request to hazard unit
- hilo_we  output  1  one-cycle HI/LO write enable
- hilo_wdata  output  2*WIDTH  {HI = remainder, LO = quotient}
- timeout  output  1  sticky watchdog error

Behaviour:
- Reset (async, rst=1): state IDLE, cycle counter 0, all outputs 0 (div_start, div_cancel, div_signed_o, div_opa, div_opb, div_stall, hilo_we, hilo_wdata, timeout).
- States: IDLE, BUSY, DONE.
- IDLE
  - div_req & ~flush: latch a, b, div_signed_i into div_opa/div_opb/div_signed_o; div_start=1 from the next cycle; go BUSY.
  - div_stall is combinational: 1 in this cycle.
- BUSY
  - div_start=1, div_stall=1; counter increments each cycle.
  - div_ready: capture div_result into hilo_wdata; div_start=0 next cycle; go DONE.
  - flush: div_cancel=1 for one cycle, div_start=0, go IDLE, no HI/LO write.
  - counter == MAX_CYCLES-1 without ready: div_cancel=1, set timeout, go IDLE, no write.
  - Priority: flush > div_ready > watchdog.
- DONE
  - div_stall=0; result held stable.
  - ~hold & ~flush: hilo_we=1 combinationally this cycle; next state IDLE.
  - hold: stay in DONE, hilo_we=0.
  - flush: go IDLE, hilo_we=0, result discarded.
- div_stall = (IDLE & div_req & ~flush) | BUSY. Never asserted in DONE, so exactly one HI/LO write per instruction.
- Back-to-back divides: the second div_req is seen in IDLE the cycle after DONE exits. No re-trigger of the same instruction, because DONE is left only when EX advances.
- Counter clears on entry to BUSY. timeout clears only on rst.
- Latched operands are not updated in BUSY/DONE; changing a/b mid-operation has no effect.
- rst mid-operation: immediate IDLE, outputs 0, no cancel pulse.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN
- Defined: in IDLE, div_req & b==0 skips the core (div_start stays 0).
  - Go directly to DONE the next cycle with hilo_wdata = {a, all-ones}; div_stall=1 for that single IDLE cycle.
- Undefined: divide-by-zero is issued to the core like any other operand and the core's result is written.

Test Plan:
- DIV, a=100, b=7, core modelled with 33-cycle latency -> div_stall high 35 cycles; one hilo_we pulse, hilo_wdata = {32'd2, 32'd14}.
- DIVU, a=32'hFFFFFFF0, b=16 -> hilo_wdata = {32'd0, 32'h0FFFFFFF}, div_signed_o=0; signed DIV, a=-7, b=2 -> {32'hFFFFFFFF, 32'hFFFFFFFD}.
- flush raised 5 cycles into BUSY -> div_cancel pulses 1 cycle, div_start drops, no hilo_we, IDLE next cycle.
- hold=1 for 3 cycles on DONE entry -> hilo_we stays 0, then pulses exactly once when hold drops; div_stall=0 throughout DONE.
- Core ready never asserted, MAX_CYCLES=40 -> div_cancel on cycle 40 of BUSY, timeout=1 sticky until rst.
- With DIV_ZERO_BYPASS_EN, a=5, b=0 -> div_start never asserted, hilo_wdata = {32'd5, 32'hFFFFFFFF}; without it the core is started.
